// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline stage: 2-entry skid buffer of {pc, instr} pairs with flush and non-32-bit flag.
// Optional IF_ID_NOP_FILL_EN: presents pc=0 / NOP_INSTR on id_* whenever the buffer is empty.
module if_id_stage #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_instr,
  output logic            if_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            id_illegal,
  input  logic            id_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } count_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

`ifdef IF_ID_NOP_FILL_EN
  localparam entry_t RESET_ENTRY = {XLEN'(0), NOP_INSTR};
`else
  localparam entry_t RESET_ENTRY = {XLEN'(0), XLEN'(0)};
`endif

  count_e state, state_n;
  entry_t e0, e0_n;
  entry_t e1, e1_n;
  entry_t incoming;
  logic   id_valid_n;
  logic   if_ready_n;
  logic   accept;
  logic   pop;

  assign incoming   = {if_pc, if_instr};
  assign accept     = if_valid && if_ready;
  assign pop        = id_valid && id_ready;
  assign id_pc      = e0.pc;
  assign id_instr   = e0.instr;
  assign id_illegal = id_valid && (e0.instr[1:0] != 2'b11);

  // State and storage registers; handshake flags kept as flops so if_ready has no comb path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      e0       <= RESET_ENTRY;
      e1       <= '0;
      id_valid <= 1'b0;
      if_ready <= 1'b1;
    end else begin
      state    <= state_n;
      e0       <= e0_n;
      e1       <= e1_n;
      id_valid <= id_valid_n;
      if_ready <= if_ready_n;
    end
  end

  // Next-state: flush wins over accept and pop; e0 is always the head.
  always_comb begin
    state_n = state;
    e0_n    = e0;
    e1_n    = e1;
    if (flush) begin
      state_n = EMPTY;
`ifdef IF_ID_NOP_FILL_EN
      e0_n    = RESET_ENTRY;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            e0_n    = incoming;
            state_n = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            e0_n = incoming;
          end else if (accept) begin
            e1_n    = incoming;
            state_n = FULL;
          end else if (pop) begin
            state_n = EMPTY;
`ifdef IF_ID_NOP_FILL_EN
            e0_n    = RESET_ENTRY;
`endif
          end
        end
        FULL: begin
          if (pop) begin
            e0_n    = e1;
            state_n = ONE;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
    id_valid_n = (state_n != EMPTY);
    if_ready_n = (state_n != FULL);
  end

endmodule
